// File: rtl/physics_step_scheduler_if.sv
// rtl/physics_step_scheduler_if.sv - engine/display handshake bundle for physics_step_scheduler (step_btn present when SINGLE_STEP_EN is defined)
interface physics_step_scheduler_if #(
  parameter int SPRITES    = 1,
  parameter int DIMENSIONS = 2,
  parameter int WIDTH      = 32,
  parameter int STEP_W     = 6
);
  localparam int LW = SPRITES * DIMENSIONS * WIDTH;

  logic              run;
  logic              frame_tick;
  logic [STEP_W-1:0] steps_per_frame;
  logic              step_start;
  logic              step_done;
  logic [LW-1:0]     locations_in;
  logic [LW-1:0]     locations_out;
  logic              snap_valid;
  logic [15:0]       frame_cnt;
  logic [7:0]        overrun_cnt;
  logic              stall;
  logic              busy;
`ifdef SINGLE_STEP_EN
  logic              step_btn;
`endif

  // Scheduler side
  modport slave (
    input  run, frame_tick, steps_per_frame, step_done, locations_in,
`ifdef SINGLE_STEP_EN
    input  step_btn,
`endif
    output step_start, locations_out, snap_valid, frame_cnt, overrun_cnt, stall, busy
  );

  // Controlling side (video timing, engine, display)
  modport master (
    output run, frame_tick, steps_per_frame, step_done, locations_in,
`ifdef SINGLE_STEP_EN
    output step_btn,
`endif
    input  step_start, locations_out, snap_valid, frame_cnt, overrun_cnt, stall, busy
  );
endinterface

// File: rtl/physics_step_scheduler.sv
// rtl/physics_step_scheduler.sv - per-frame physics step sequencer with location snapshot; optional SINGLE_STEP_EN adds step_btn single-stepping
module physics_step_scheduler #(
  parameter int SPRITES    = 1,
  parameter int DIMENSIONS = 2,
  parameter int WIDTH      = 32,
  parameter int STEP_W     = 6,
  parameter int TIMEOUT    = 65535
) (
  input  logic                    clk,
  input  logic                    rst_l,
  physics_step_scheduler_if.slave bus
);
  localparam int LW = SPRITES * DIMENSIONS * WIDTH;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_ISSUE, S_WAIT_DONE, S_SNAP} state_t;

  state_t            state_q, state_d;
  logic [STEP_W-1:0] n_q, n_d;
  logic [STEP_W-1:0] k_q, k_d;
  logic [STEP_W-1:0] k_inc;
  logic [TW-1:0]     timer_q, timer_d;
  logic              stall_q, stall_d;
  logic              snap_q, snap_d;
  logic [LW-1:0]     loc_q;
  logic [15:0]       frame_cnt_q;
  logic [7:0]        overrun_q;
  logic              in_frame;
  logic              btn_rise;

`ifdef SINGLE_STEP_EN
  logic btn_q;

  // Remember the previous button level so only a rising edge starts a step
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) btn_q <= 1'b0;
    else        btn_q <= bus.step_btn;
  end

  assign btn_rise = bus.step_btn & ~btn_q;
`else
  assign btn_rise = 1'b0;
`endif

  assign k_inc    = k_q + 1'b1;
  assign in_frame = (state_q == S_ISSUE) || (state_q == S_WAIT_DONE) || (state_q == S_SNAP);

  // Next-state logic: frame sequencing, step counting and stall detection
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    timer_d = timer_q;
    stall_d = stall_q;
    case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          state_d = S_ARMED;
        end else if (btn_rise) begin
          // Manual single step reuses the normal path with a one-step frame
          n_d     = STEP_W'(1);
          k_d     = '0;
          state_d = S_ISSUE;
        end
      end
      S_ARMED: begin
        if (!bus.run) begin
          state_d = S_IDLE;
        end else if (bus.frame_tick) begin
          n_d     = bus.steps_per_frame;
          k_d     = '0;
          state_d = (bus.steps_per_frame == '0) ? S_SNAP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (bus.step_done) begin
          k_d     = k_inc;
          state_d = ((k_inc == n_q) || !bus.run) ? S_SNAP : S_ISSUE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          // Engine never answered: give up on this frame without a snapshot
          stall_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_SNAP: begin
        state_d = bus.run ? S_ARMED : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Capture on entry so snap_valid and the new locations appear together
    snap_d = (state_d == S_SNAP);
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      k_q     <= '0;
      timer_q <= '0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      timer_q <= timer_d;
      stall_q <= stall_d;
    end
  end

  // Display snapshot bank, frame counter and saturating overrun counter
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      snap_q      <= 1'b0;
      loc_q       <= '0;
      frame_cnt_q <= '0;
      overrun_q   <= '0;
    end else begin
      snap_q <= snap_d;
      if (snap_d) begin
        loc_q       <= bus.locations_in;
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (bus.frame_tick && in_frame && (overrun_q != 8'hFF)) begin
        overrun_q <= overrun_q + 8'd1;
      end
    end
  end

  assign bus.step_start    = (state_q == S_ISSUE);
  assign bus.busy          = in_frame;
  assign bus.snap_valid    = snap_q;
  assign bus.locations_out = loc_q;
  assign bus.frame_cnt     = frame_cnt_q;
  assign bus.overrun_cnt   = overrun_q;
  assign bus.stall         = stall_q;
endmodule

// File: tb/tb_physics_step_scheduler.sv
// tb/tb_physics_step_scheduler.sv - scoreboard bench for physics_step_scheduler
module tb_physics_step_scheduler;
  localparam logic [63:0] INC = 64'h0000_0010_0000_0003;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  physics_step_scheduler_if #(.SPRITES(1), .DIMENSIONS(2), .WIDTH(32), .STEP_W(6)) bus ();

  physics_step_scheduler #(
    .SPRITES(1), .DIMENSIONS(2), .WIDTH(32), .STEP_W(6), .TIMEOUT(16)
  ) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  int          checks = 0;
  int          failures = 0;
  int          step_cnt = 0;
  int          snap_cnt = 0;
  int          s0;
  bit          engine_en = 1'b1;
  int          cd = 0;
  logic [15:0] exp_fc = '0;
  logic [63:0] last_loc = '0;
  logic [63:0] exp_loc_q[$];
  logic [15:0] exp_fc_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_frame(input int n);
    exp_fc   = exp_fc + 16'd1;
    last_loc = bus.locations_in + 64'(n) * INC;
    exp_loc_q.push_back(last_loc);
    exp_fc_q.push_back(exp_fc);
  endtask

  task automatic tick(input int n);
    bus.steps_per_frame = 6'(n);
    bus.frame_tick      = 1'b1;
    cyc(1);
    bus.frame_tick      = 1'b0;
  endtask

  task automatic wait_snaps(input int target, input int budget);
    int i;
    i = 0;
    while (snap_cnt < target && i < budget) begin
      cyc(1);
      i++;
    end
    chk("wait_snap", 64'(snap_cnt >= target), 64'd1);
  endtask

  // Engine model: answers each step_start with step_done 5 cycles later and moves locations
  initial begin
    bus.step_done    = 1'b0;
    bus.locations_in = 64'h1234_5678_0000_0100;
    forever begin
      @(negedge clk);
      bus.step_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.step_done    = 1'b1;
          bus.locations_in = bus.locations_in + INC;
        end
      end
      if (bus.step_start && engine_en) cd = 4;
    end
  end

  // Output monitor: counts steps, pops the scoreboard on every snapshot
  initial begin
    forever begin
      @(negedge clk);
      if (bus.step_start) step_cnt++;
      if (bus.snap_valid) begin
        snap_cnt++;
        if (exp_loc_q.size() == 0) begin
          chk("unexpected_snap", 64'd1, 64'd0);
        end else begin
          chk("snap_loc", bus.locations_out, exp_loc_q.pop_front());
          chk("snap_frame_cnt", 64'(bus.frame_cnt), 64'(exp_fc_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.run             = 1'b0;
    bus.frame_tick      = 1'b0;
    bus.steps_per_frame = '0;
`ifdef SINGLE_STEP_EN
    bus.step_btn        = 1'b0;
`endif
    cyc(3);
    chk("rst_step_start", 64'(bus.step_start), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_snap_valid", 64'(bus.snap_valid), 64'd0);
    chk("rst_frame_cnt", 64'(bus.frame_cnt), 64'd0);
    chk("rst_overrun", 64'(bus.overrun_cnt), 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    chk("rst_loc", bus.locations_out, 64'd0);
    rst_l = 1'b1;

    // Three steps in one frame
    bus.run = 1'b1;
    cyc(2);
    s0 = step_cnt;
    push_frame(3);
    tick(3);
    chk("t1_start_latency", 64'(bus.step_start), 64'd1);
    wait_snaps(1, 200);
    cyc(1);
    chk("t1_steps", 64'(step_cnt - s0), 64'd3);
    chk("t1_frame_cnt", 64'(bus.frame_cnt), 64'd1);

    // Zero steps: snapshot right after the tick
    s0 = step_cnt;
    push_frame(0);
    tick(0);
    chk("t2_snap_next", 64'(bus.snap_valid), 64'd1);
    wait_snaps(2, 10);
    cyc(1);
    chk("t2_no_steps", 64'(step_cnt - s0), 64'd0);

    // Tick during a frame is dropped and counted
    s0 = step_cnt;
    push_frame(4);
    tick(4);
    cyc(3);
    bus.frame_tick = 1'b1;
    cyc(1);
    bus.frame_tick = 1'b0;
    chk("t3_overrun1", 64'(bus.overrun_cnt), 64'd1);
    wait_snaps(3, 200);
    cyc(1);
    chk("t3_steps", 64'(step_cnt - s0), 64'd4);

    // 300 dropped ticks saturate the overrun counter
    s0 = step_cnt;
    push_frame(63);
    tick(63);
    bus.frame_tick = 1'b1;
    cyc(300);
    bus.frame_tick = 1'b0;
    chk("t3_overrun_sat", 64'(bus.overrun_cnt), 64'hFF);
    wait_snaps(4, 600);
    cyc(1);
    chk("t3_steps63", 64'(step_cnt - s0), 64'd63);

    // Engine never answers: stall after TIMEOUT cycles, no snapshot
    engine_en = 1'b0;
    s0 = step_cnt;
    tick(2);
    cyc(8);
    chk("t4_stall_early", 64'(bus.stall), 64'd0);
    cyc(12);
    chk("t4_stall", 64'(bus.stall), 64'd1);
    chk("t4_busy", 64'(bus.busy), 64'd0);
    chk("t4_loc_held", bus.locations_out, last_loc);
    chk("t4_no_snap", 64'(snap_cnt), 64'd4);
    chk("t4_one_step", 64'(step_cnt - s0), 64'd1);

    // Reset in the middle of WAIT_DONE
    engine_en = 1'b1;
    tick(3);
    cyc(3);
    rst_l = 1'b0;
    #1;
    chk("t5_step_start", 64'(bus.step_start), 64'd0);
    chk("t5_busy", 64'(bus.busy), 64'd0);
    chk("t5_stall", 64'(bus.stall), 64'd0);
    chk("t5_frame_cnt", 64'(bus.frame_cnt), 64'd0);
    chk("t5_overrun", 64'(bus.overrun_cnt), 64'd0);
    chk("t5_loc", bus.locations_out, 64'd0);
    cyc(10);
    exp_fc = '0;
    rst_l  = 1'b1;
    cyc(2);
    push_frame(2);
    tick(2);
    wait_snaps(5, 200);
    cyc(1);
    chk("t5_frame_after", 64'(bus.frame_cnt), 64'd1);

`ifdef SINGLE_STEP_EN
    // Held button produces a single step and snapshot
    bus.run = 1'b0;
    cyc(3);
    s0 = step_cnt;
    push_frame(1);
    bus.step_btn = 1'b1;
    cyc(100);
    bus.step_btn = 1'b0;
    wait_snaps(6, 50);
    cyc(2);
    chk("t6_one_step", 64'(step_cnt - s0), 64'd1);
    chk("t6_idle", 64'(bus.busy), 64'd0);
`endif

    cyc(2);
    chk("sb_empty", 64'(exp_loc_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
